// File: rtl/maze_map_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : maze_map_arbiter
//  Purpose  : Shares the single-port maze map memory between the VGA cell
//             renderer (REN) and the game move/collision logic (GM).
//             The renderer has priority during active video and the game has
//             priority during vertical blank. The block also produces the
//             per-frame o_DrawDone pulse that gates game-state MOVE commits.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_Clk        system clock
//    i_Rst        asynchronous, active-low reset
//    i_vBlank     vertical blank level from the sync generator
//    i_Ren_Req    renderer read request, one address per cycle
//    i_Ren_Addr   renderer cell address
//    o_Ren_Valid  renderer read data valid (one cycle)
//    o_Ren_Data   renderer read data (holds between valids)
//    o_Ren_Miss   renderer request lost to GM this cycle (blank only)
//    i_Gm_Req     game read request, held with stable address until ack
//    i_Gm_Addr    game cell address
//    o_Gm_Ack     game request issued to memory this cycle
//    o_Gm_Valid   game read data valid (one cycle)
//    o_Gm_Data    game read data (holds between valids)
//    o_Mem_En     map memory read enable
//    o_Mem_Addr   map memory address (held when idle)
//    i_Mem_Data   map memory data, MEM_LAT cycles after o_Mem_En
//    o_DrawDone   one-cycle pulse in the first cycle of each vertical blank
//    o_Starve     game has waited STARVE_MAX or more cycles
// ============================================================================
module maze_map_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 1,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 1023
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_vBlank,
    input  logic              i_Ren_Req,
    input  logic [ADDR_W-1:0] i_Ren_Addr,
    output logic              o_Ren_Valid,
    output logic [DATA_W-1:0] o_Ren_Data,
    output logic              o_Ren_Miss,
    input  logic              i_Gm_Req,
    input  logic [ADDR_W-1:0] i_Gm_Addr,
    output logic              o_Gm_Ack,
    output logic              o_Gm_Valid,
    output logic [DATA_W-1:0] o_Gm_Data,
    output logic              o_Mem_En,
    output logic [ADDR_W-1:0] o_Mem_Addr,
    input  logic [DATA_W-1:0] i_Mem_Data,
    output logic              o_DrawDone,
    output logic              o_Starve
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] c_starve_max = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

    // ACTIVE/BLANK doubles as the registered sample of i_vBlank.
    typedef enum logic [0:0] {
        ST_ACTIVE = 1'b0,
        ST_BLANK  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q,     state_d;
    logic                draw_done_q, draw_done_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [CNT_W-1:0]    wait_cnt_q,  wait_cnt_d;
    logic [DATA_W-1:0]   ren_data_q,  ren_data_d;
    logic [DATA_W-1:0]   gm_data_q,   gm_data_d;

    // Owner pipeline: one slot per cycle of memory latency. tag_vld marks an
    // issued read, tag_gm records whether GM (1) or REN (0) owns it.
    logic [MEM_LAT-1:0]  tag_vld_q,   tag_vld_d;
    logic [MEM_LAT-1:0]  tag_gm_q,    tag_gm_d;

    // ------------------------------------------------------------------
    // Combinational grant and routing
    // ------------------------------------------------------------------
    logic                w_gm_grant;
    logic                w_ren_grant;
    logic                w_exit_vld;
    logic                w_exit_gm;
    logic [ADDR_W-1:0]   w_mem_addr;

    always_comb begin
        // Grants are qualified with reset so that every output reads 0
        // while the block is held in reset, even with requests pending.
        w_gm_grant  = i_Rst && i_Gm_Req && ((state_q == ST_BLANK) || !i_Ren_Req);
        w_ren_grant = i_Rst && i_Ren_Req && !w_gm_grant;

        if (w_gm_grant) begin
            w_mem_addr = i_Gm_Addr;
        end else if (w_ren_grant) begin
            w_mem_addr = i_Ren_Addr;
        end else begin
            w_mem_addr = mem_addr_q;
        end

        w_exit_vld = tag_vld_q[MEM_LAT-1];
        w_exit_gm  = tag_gm_q[MEM_LAT-1];
    end

    assign o_Mem_En    = w_gm_grant || w_ren_grant;
    assign o_Mem_Addr  = w_mem_addr;
    assign o_Gm_Ack    = w_gm_grant;
    // REN can only lose while GM holds priority, i.e. during blank.
    assign o_Ren_Miss  = i_Ren_Req && w_gm_grant;

    assign o_Ren_Valid = w_exit_vld && !w_exit_gm;
    assign o_Gm_Valid  = w_exit_vld &&  w_exit_gm;
    assign o_Ren_Data  = o_Ren_Valid ? i_Mem_Data : ren_data_q;
    assign o_Gm_Data   = o_Gm_Valid  ? i_Mem_Data : gm_data_q;

    assign o_DrawDone  = draw_done_q;
    assign o_Starve    = (wait_cnt_q == c_starve_max);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = i_vBlank ? ST_BLANK : ST_ACTIVE;
        // Pulse coincides with the first BLANK cycle.
        draw_done_d = (state_q == ST_ACTIVE) && i_vBlank;
        mem_addr_d  = w_mem_addr;
        ren_data_d  = o_Ren_Data;
        gm_data_d   = o_Gm_Data;

        tag_vld_d    = '0;
        tag_gm_d     = '0;
        tag_vld_d[0] = w_gm_grant || w_ren_grant;
        tag_gm_d[0]  = w_gm_grant;
        for (int i = 1; i < MEM_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_gm_d[i]  = tag_gm_q[i-1];
        end

        // A dropped request or a grant restarts the wait measurement.
        if (!i_Gm_Req || w_gm_grant) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != c_starve_max) begin
            wait_cnt_d = wait_cnt_q + c_cnt_one;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q     <= ST_ACTIVE;
            draw_done_q <= 1'b0;
            mem_addr_q  <= '0;
            wait_cnt_q  <= '0;
            ren_data_q  <= '0;
            gm_data_q   <= '0;
            tag_vld_q   <= '0;
            tag_gm_q    <= '0;
        end else begin
            state_q     <= state_d;
            draw_done_q <= draw_done_d;
            mem_addr_q  <= mem_addr_d;
            wait_cnt_q  <= wait_cnt_d;
            ren_data_q  <= ren_data_d;
            gm_data_q   <= gm_data_d;
            tag_vld_q   <= tag_vld_d;
            tag_gm_q    <= tag_gm_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_maze_map_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_maze_map_arbiter
//  Purpose  : Self-checking bench for maze_map_arbiter. Two instances share
//             the same stimulus, one with MEM_LAT=1 and one with MEM_LAT=3,
//             each with its own behavioural map memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_maze_map_arbiter;

    localparam int AW   = 11;
    localparam int SMAX = 1023;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vblank, ren_req, gm_req;
    logic [AW-1:0] ren_addr, gm_addr;

    logic          r1_valid, r1_data, r1_miss, g1_ack, g1_valid, g1_data, m1_en, dd1, st1;
    logic          r3_valid, r3_data, r3_miss, g3_ack, g3_valid, g3_data, m3_en, dd3, st3;
    logic [AW-1:0] m1_addr, m3_addr;
    logic          mp1;
    logic [2:0]    mp3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    maze_map_arbiter #(.ADDR_W(AW), .DATA_W(1), .MEM_LAT(1), .STARVE_MAX(SMAX)) dut1 (
        .i_Clk(clk), .i_Rst(rst_n), .i_vBlank(vblank),
        .i_Ren_Req(ren_req), .i_Ren_Addr(ren_addr),
        .o_Ren_Valid(r1_valid), .o_Ren_Data(r1_data), .o_Ren_Miss(r1_miss),
        .i_Gm_Req(gm_req), .i_Gm_Addr(gm_addr),
        .o_Gm_Ack(g1_ack), .o_Gm_Valid(g1_valid), .o_Gm_Data(g1_data),
        .o_Mem_En(m1_en), .o_Mem_Addr(m1_addr), .i_Mem_Data(mp1),
        .o_DrawDone(dd1), .o_Starve(st1));

    maze_map_arbiter #(.ADDR_W(AW), .DATA_W(1), .MEM_LAT(3), .STARVE_MAX(SMAX)) dut3 (
        .i_Clk(clk), .i_Rst(rst_n), .i_vBlank(vblank),
        .i_Ren_Req(ren_req), .i_Ren_Addr(ren_addr),
        .o_Ren_Valid(r3_valid), .o_Ren_Data(r3_data), .o_Ren_Miss(r3_miss),
        .i_Gm_Req(gm_req), .i_Gm_Addr(gm_addr),
        .o_Gm_Ack(g3_ack), .o_Gm_Valid(g3_valid), .o_Gm_Data(g3_data),
        .o_Mem_En(m3_en), .o_Mem_Addr(m3_addr), .i_Mem_Data(mp3[2]),
        .o_DrawDone(dd3), .o_Starve(st3));

    // Map memory contents and latency pipes (random data when not enabled).
    logic mem [0:2047];

    always @(posedge clk) begin
        mp1 <= m1_en ? mem[m1_addr] : 1'($urandom);
        mp3 <= {mp3[1:0], (m3_en ? mem[m3_addr] : 1'($urandom))};
    end

    // ------------------------------------------------------------------
    // Reference model: grant rules plus a history of issued reads; a read
    // issued in cycle c must return to its owner in cycle c+LAT.
    // ------------------------------------------------------------------
    int            cyc;
    logic          m_vb, m_vb_prev;
    int            m_cnt;
    logic [AW-1:0] m_last;
    logic          hv [8];
    logic          ho [8];
    logic [AW-1:0] ha [8];
    logic          m_rd1, m_gd1, m_rd3, m_gd3;
    logic          p_gw, p_en;
    logic [AW-1:0] p_addr;
    logic          p_rd1, p_gd1, p_rd3, p_gd3;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0b expected %0b", nm, cyc, act, exp);
        end
    endtask

    task automatic chka(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_vb = 1'b0; m_vb_prev = 1'b0; m_cnt = 0; m_last = '0;
        m_rd1 = 1'b0; m_gd1 = 1'b0; m_rd3 = 1'b0; m_gd3 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            hv[i] = 1'b0; ho[i] = 1'b0; ha[i] = '0;
        end
    endtask

    task automatic model_check();
        logic gw, rw, miss, dd, st, v1, o1, d1, v3, o3, d3;
        int i1, i3;
        gw     = gm_req && (m_vb || !ren_req);
        rw     = ren_req && !gw;
        p_gw   = gw;
        p_en   = gw || rw;
        p_addr = gw ? gm_addr : (rw ? ren_addr : m_last);
        miss   = ren_req && gw;
        dd     = m_vb && !m_vb_prev;
        st     = (m_cnt == SMAX);
        i1 = (cyc - 1) & 7;
        i3 = (cyc - 3) & 7;
        v1 = hv[i1]; o1 = ho[i1]; d1 = mem[ha[i1]];
        v3 = hv[i3]; o3 = ho[i3]; d3 = mem[ha[i3]];
        p_rd1 = (v1 && !o1) ? d1 : m_rd1;
        p_gd1 = (v1 &&  o1) ? d1 : m_gd1;
        p_rd3 = (v3 && !o3) ? d3 : m_rd3;
        p_gd3 = (v3 &&  o3) ? d3 : m_gd3;
        chk1("mem_en1", m1_en, p_en);      chk1("mem_en3", m3_en, p_en);
        chka("mem_addr1", m1_addr, p_addr); chka("mem_addr3", m3_addr, p_addr);
        chk1("gm_ack1", g1_ack, gw);       chk1("gm_ack3", g3_ack, gw);
        chk1("ren_miss1", r1_miss, miss);  chk1("ren_miss3", r3_miss, miss);
        chk1("drawdone1", dd1, dd);        chk1("drawdone3", dd3, dd);
        chk1("starve1", st1, st);          chk1("starve3", st3, st);
        chk1("ren_valid1", r1_valid, v1 && !o1);
        chk1("gm_valid1",  g1_valid, v1 &&  o1);
        chk1("ren_valid3", r3_valid, v3 && !o3);
        chk1("gm_valid3",  g3_valid, v3 &&  o3);
        chk1("ren_data1", r1_data, p_rd1); chk1("gm_data1", g1_data, p_gd1);
        chk1("ren_data3", r3_data, p_rd3); chk1("gm_data3", g3_data, p_gd3);
    endtask

    task automatic cyc_begin();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        hv[cyc & 7] = p_en;
        ho[cyc & 7] = p_gw;
        ha[cyc & 7] = p_addr;
        m_last = p_addr;
        if (!gm_req || p_gw)  m_cnt = 0;
        else if (m_cnt < SMAX) m_cnt = m_cnt + 1;
        m_vb_prev = m_vb;
        m_vb = vblank;
        m_rd1 = p_rd1; m_gd1 = p_gd1; m_rd3 = p_rd3; m_gd3 = p_gd3;
        cyc++;
        #1;
    endtask

    task automatic step();
        cyc_begin();
        advance();
    endtask

    task automatic check_zero(input string nm);
        chk1({nm, "_r1v"}, r1_valid, 1'b0); chk1({nm, "_r3v"}, r3_valid, 1'b0);
        chk1({nm, "_g1v"}, g1_valid, 1'b0); chk1({nm, "_g3v"}, g3_valid, 1'b0);
        chk1({nm, "_r1d"}, r1_data, 1'b0);  chk1({nm, "_g3d"}, g3_data, 1'b0);
        chk1({nm, "_miss"}, r1_miss | r3_miss, 1'b0);
        chk1({nm, "_ack"}, g1_ack | g3_ack, 1'b0);
        chk1({nm, "_en"}, m1_en | m3_en, 1'b0);
        chka({nm, "_addr1"}, m1_addr, '0); chka({nm, "_addr3"}, m3_addr, '0);
        chk1({nm, "_dd"}, dd1 | dd3, 1'b0);
        chk1({nm, "_st"}, st1 | st3, 1'b0);
    endtask

    typedef struct {
        logic          vb, ren, gm;
        logic [AW-1:0] ra, ga;
        logic          e_en, e_ack, e_miss;
        logic [AW-1:0] e_addr;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic last_ack;

        //            vb    ren   gm    ra      ga      en    ack   miss  addr
        tbl[0] = '{1'b0, 1'b1, 1'b1, 11'h005, 11'h02A, 1'b1, 1'b0, 1'b0, 11'h005};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 11'h000, 11'h033, 1'b1, 1'b1, 1'b0, 11'h033};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 11'h123, 11'h456, 1'b0, 1'b0, 1'b0, 11'h033};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 11'h007, 11'h02A, 1'b1, 1'b1, 1'b1, 11'h02A};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 11'h100, 11'h000, 1'b1, 1'b0, 1'b0, 11'h100};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 11'h000, 11'h7FF, 1'b1, 1'b1, 1'b0, 11'h7FF};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 11'h001, 11'h002, 1'b0, 1'b0, 1'b0, 11'h7FF};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 11'h000, 11'h000, 1'b1, 1'b0, 1'b0, 11'h000};

        for (int i = 0; i < 2048; i++) mem[i] = 1'($urandom);
        cyc = 16;
        rst_n = 1'b0; vblank = 1'b0; ren_req = 1'b0; gm_req = 1'b0;
        ren_addr = '0; gm_addr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // REN streams 0..N in ACTIVE while GM waits until starvation.
        gm_req = 1'b1; gm_addr = 11'h055; ren_req = 1'b1;
        for (int j = 0; j < 1031; j++) begin
            ren_addr = AW'(j);
            cyc_begin();
            if (j < 10) chka("t1_addr", m1_addr, AW'(j));
            chk1("t1_noack", g1_ack, 1'b0);
            if (j >= 1 && j <= 10) chk1("t1_valid1", r1_valid, 1'b1);
            if (j == 1022 || j == 1023) chk1("t1_starve", st1, (j >= 1023));
            advance();
        end

        // REN gap: pending GM wins it and the wait counter restarts.
        ren_req = 1'b0;
        cyc_begin();
        chk1("t4_ack", g1_ack, 1'b1);
        chka("t4_addr", m1_addr, 11'h055);
        chk1("t4_starve_held", st1, 1'b1);
        advance();
        ren_req = 1'b1; gm_addr = 11'h056;
        cyc_begin();
        chk1("t4_ack2", g1_ack, 1'b0);
        chk1("t4_starve_clr", st1, 1'b0);
        advance();
        ren_req = 1'b0; gm_req = 1'b0;
        repeat (3) step();

        // DrawDone: one pulse on entry to blank, none on exit.
        vblank = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc_begin();
            chk1("t2_dd_rise", dd1, (k == 1));
            advance();
        end
        vblank = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc_begin();
            chk1("t2_dd_fall", dd1, 1'b0);
            advance();
        end

        // Grant table.
        for (int t = 0; t < 8; t++) begin
            vblank = tbl[t].vb; ren_req = 1'b0; gm_req = 1'b0;
            step();
            ren_req = tbl[t].ren; gm_req = tbl[t].gm;
            ren_addr = tbl[t].ra; gm_addr = tbl[t].ga;
            cyc_begin();
            chk1("tbl_en", m1_en, tbl[t].e_en);
            chk1("tbl_ack", g1_ack, tbl[t].e_ack);
            chk1("tbl_miss", r1_miss, tbl[t].e_miss);
            chka("tbl_addr", m1_addr, tbl[t].e_addr);
            advance();
            if (t == 3) begin
                ren_req = 1'b0; gm_req = 1'b0;
                cyc_begin();
                chk1("t3_gm_valid", g1_valid, 1'b1);
                chk1("t3_gm_data", g1_data, mem[11'h02A]);
                advance();
            end
        end
        ren_req = 1'b0; gm_req = 1'b0; vblank = 1'b0;
        repeat (3) step();

        // Alternating owners through the 3-cycle instance.
        for (int k = 0; k < 10; k++) begin
            ren_req  = (k < 6) && (k % 2 == 0);
            gm_req   = (k < 6) && (k % 2 == 1);
            ren_addr = AW'(100 + k);
            gm_addr  = AW'(200 + k);
            cyc_begin();
            if (k >= 3 && k < 9) begin
                chk1("t5_ren_valid3", r3_valid, ((k - 3) % 2 == 0));
                chk1("t5_gm_valid3",  g3_valid, ((k - 3) % 2 == 1));
                if ((k - 3) % 2 == 0) chk1("t5_ren_data3", r3_data, mem[AW'(100 + k - 3)]);
                else                  chk1("t5_gm_data3",  g3_data, mem[AW'(200 + k - 3)]);
            end
            advance();
        end

        // Randomized traffic with blank toggling.
        last_ack = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) vblank = ~vblank;
            ren_req  = ($urandom_range(0, 3) != 0);
            ren_addr = AW'($urandom);
            if (!gm_req || last_ack) begin
                gm_req  = ($urandom_range(0, 2) == 0);
                gm_addr = AW'($urandom);
            end
            cyc_begin();
            last_ack = p_gw;
            advance();
        end

        // Reset with reads in flight.
        vblank = 1'b0; ren_req = 1'b0; gm_req = 1'b0;
        repeat (2) step();
        ren_req = 1'b1; ren_addr = 11'h011;
        step();
        ren_req = 1'b0; gm_req = 1'b1; gm_addr = 11'h022;
        step();
        ren_req = 1'b1; ren_addr = 11'h033; gm_addr = 11'h044;
        cyc_begin();
        #1 rst_n = 1'b0;
        #1 check_zero("rst_mid");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("rst_hold");
        @(posedge clk); #1;
        rst_n = 1'b1; ren_req = 1'b0; gm_req = 1'b0;
        model_reset();
        for (int k = 0; k < 5; k++) begin
            cyc_begin();
            chk1("t6_no_valid", r1_valid | g1_valid | r3_valid | g3_valid, 1'b0);
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
